// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin grant arbiter.
package arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int N_REQ_DEF    = 4;
   localparam int MAX_HOLD_DEF = 16;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set req bit at or after ptr, wrapping.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          valid,
   output logic [IW-1:0] idx
);

   always_comb begin
      int j;
      valid = 1'b0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         j = int'(ptr) + i;
         if (j >= N) j = j - N;
         if (!valid && req[j]) begin
            valid = 1'b1;
            idx   = IW'(j);
         end
      end
   end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot grant and bounded hold time.
module rr_grant_arbiter
   import arb_pkg::*;
#(
   parameter int N_REQ    = N_REQ_DEF,
   parameter int MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   output logic [N_REQ-1:0]         gnt,
   output logic [$clog2(N_REQ)-1:0] gnt_id,
   output logic                     busy,
   output logic                     timeout
);

   localparam int IW = $clog2(N_REQ);
   localparam int HW = $clog2(MAX_HOLD);

   state_t            state, state_n;
   logic [N_REQ-1:0]  gnt_n;
   logic [IW-1:0]     id_n;
   logic [IW-1:0]     rr_ptr, ptr_n;
   logic [HW-1:0]     hold_cnt, hold_n;
   logic              to_n;
   logic              pick_valid;
   logic [IW-1:0]     pick_idx;
   logic [IW-1:0]     next_owner;

   rr_pick #(
      .N  (N_REQ),
      .IW (IW)
   ) u_pick (
      .req   (req),
      .ptr   (rr_ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   assign next_owner = (gnt_id == IW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
   assign busy       = |gnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= '0;
         gnt_id   <= '0;
         rr_ptr   <= '0;
         hold_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         state    <= state_n;
         gnt      <= gnt_n;
         gnt_id   <= id_n;
         rr_ptr   <= ptr_n;
         hold_cnt <= hold_n;
         timeout  <= to_n;
      end
   end

   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      id_n    = gnt_id;
      ptr_n   = rr_ptr;
      hold_n  = hold_cnt;
      to_n    = 1'b0;
      unique case (state)
         IDLE: begin
            if (pick_valid) begin
               state_n = GRANT;
               gnt_n   = N_REQ'(1) << pick_idx;
               id_n    = pick_idx;
               hold_n  = '0;
            end
         end
         GRANT: begin
            // Owner drop and hold expiry share one release path.
            if (!req[gnt_id] || hold_cnt == HW'(MAX_HOLD - 1)) begin
               state_n = IDLE;
               gnt_n   = '0;
               id_n    = '0;
               hold_n  = '0;
               ptr_n   = next_owner;
               to_n    = req[gnt_id];
            end else begin
               hold_n = hold_cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   a_onehot: assert property (@(posedge clk) $onehot0(gnt));
   a_busy:   assert property (@(posedge clk) busy == (|gnt));
   a_rose:   assert property (@(posedge clk) disable iff (rst)
                $rose(busy) |-> $past(|req));
   a_to:     assert property (@(posedge clk) disable iff (rst)
                timeout |-> $fell(busy));

endmodule

// File: doc/rr_grant_arbiter.md
RR_GRANT_ARBITER -- requirements
Module: rr_grant_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, meaning number of requesters (2..8).
REQ-002 Parameter MAX_HOLD, default 16, meaning maximum consecutive grant cycles before forced release (>=2).
REQ-003 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port req  input  N_REQ  per-requester request level, held high for the whole transaction.
REQ-006 Port gnt  output  N_REQ  registered grant, one-hot or zero.
REQ-007 Port gnt_id  output  $clog2(N_REQ)  index of current owner; 0 when gnt is zero.
REQ-008 Port busy  output  1  high exactly when gnt is nonzero.
REQ-009 Port timeout  output  1  one-cycle pulse on a forced release.

Function
REQ-010 The FSM SHALL have two states: IDLE and GRANT.
REQ-011 In IDLE with req nonzero, the block SHALL select the first set req bit at or after rr_ptr, wrapping modulo N_REQ, and enter GRANT at the next edge.
REQ-012 Grant latency SHALL be exactly one cycle: req sampled high at edge t gives gnt high after edge t.
REQ-013 In IDLE with req zero, state, rr_ptr and all outputs SHALL hold at their idle values.
REQ-014 In GRANT, gnt SHALL remain constant and ignore req of non-owners.
REQ-015 hold_cnt SHALL clear on grant entry, increment by 1 per GRANT cycle, and be $clog2(MAX_HOLD) bits wide with no wrap.
REQ-016 Owner release: req[owner] sampled low SHALL clear gnt at that edge, enter IDLE and set rr_ptr to (owner+1) mod N_REQ.
REQ-017 Forced release: req[owner] high with hold_cnt == MAX_HOLD-1 SHALL do the same as REQ-016 and pulse timeout for exactly one cycle.
REQ-018 Every release SHALL be followed by at least one cycle with gnt zero (dead cycle) before any new grant.
REQ-019 A timed-out owner that is the sole requester SHALL be re-granted after the dead cycle.
REQ-020 gnt, gnt_id and busy SHALL always be mutually consistent (REQ-007, REQ-008).
REQ-021 gnt SHALL never have more than one bit set.

Reset
REQ-022 rst high at an edge SHALL force state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, hold_cnt=0, rr_ptr=0.
REQ-023 Reset asserted mid-GRANT SHALL take priority over release and timeout logic, and SHALL NOT pulse timeout.
REQ-024 The first arbitration after reset release SHALL be evaluated at the first edge with rst low.

Structure
REQ-025 Shared package arb_pkg SHALL hold the state enum (IDLE, GRANT) and default constants N_REQ_DEF=4 and MAX_HOLD_DEF=16.
REQ-026 Rotating-priority selection SHALL be in one combinational sub-module rr_pick with inputs req and ptr and outputs valid and idx.
REQ-027 Concurrent assertions SHALL cover: onehot0(gnt); busy==|gnt; $rose(busy) implies $past(|req); timeout implies $fell(busy).

Verification
REQ-028 After reset, req=4'b0100 at edge 3 -> gnt=4'b0100 and gnt_id=2 after edge 3; req low at edge 6 -> gnt=0 after edge 6.
REQ-029 req=4'b1111 held, every owner releasing after 2 cycles -> grant order 0,1,2,3,0 with one dead cycle between grants.
REQ-030 req=4'b0001 held for 30 cycles -> timeout pulses after grant cycle 16, dead cycle follows, then gnt=4'b0001 again.
REQ-031 Owner 1 granted with req[3] rising mid-grant -> gnt stays 4'b0010 until release, then gnt=4'b1000 after the dead cycle.
REQ-032 rst pulsed during GRANT at hold_cnt=5 -> all outputs 0 at the next edge, no timeout, and a following req[0] is granted (rr_ptr=0).
